// File: rtl/rv32_muldiv_unit.sv
// rv32_muldiv_unit: RV32M multiply/divide unit, radix-2 iterative; define RV32_MULDIV_SINGLE_CYCLE_MUL_EN for a one-cycle multiplier
module rv32_muldiv_unit #(
  parameter int XLEN_P = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        op_i,
  input  logic [XLEN_P-1:0] operand_a_i,
  input  logic [XLEN_P-1:0] operand_b_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN_P-1:0] result_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int CW = $clog2(XLEN_P) + 1;
  state_e state_q, state_d;
  logic [2:0] op_q;
  logic [CW-1:0] cnt_q;
  logic [2*XLEN_P-1:0] acc_q, acc_mul, acc_div, acc_nxt, prod;
  logic [XLEN_P-1:0] b_q, res_q, a_mag, b_mag, sp_res, mul_res, quo, rem, fin;
  logic [XLEN_P:0] sum, sh, diff;
  logic neg_q, rneg_q, accept, last, a_neg, b_neg, div_zero, ovf, fast_mul, special;
`ifdef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
  logic [2*XLEN_P-1:0] full;
`endif
  always_comb begin
    accept   = valid_i && state_q == IDLE && !flush_i;
    last     = cnt_q == CW'(XLEN_P - 1);
    a_neg    = (op_i inside {3'd1, 3'd2, 3'd4, 3'd6}) && operand_a_i[XLEN_P-1];
    b_neg    = (op_i inside {3'd1, 3'd4, 3'd6}) && operand_b_i[XLEN_P-1];
    a_mag    = a_neg ? -operand_a_i : operand_a_i;
    b_mag    = b_neg ? -operand_b_i : operand_b_i;
    div_zero = op_i[2] && operand_b_i == '0;
    ovf      = op_i[2] && !op_i[0] && operand_a_i == {1'b1, {(XLEN_P-1){1'b0}}} && operand_b_i == '1;
`ifdef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
    full     = {{XLEN_P{a_neg}}, operand_a_i} * {{XLEN_P{b_neg}}, operand_b_i};
    fast_mul = !op_i[2];
    mul_res  = op_i == 3'd0 ? full[XLEN_P-1:0] : full[2*XLEN_P-1:XLEN_P];
`else
    fast_mul = 1'b0;
    mul_res  = '0;
`endif
    special  = div_zero || ovf || fast_mul;
    sp_res   = div_zero ? (op_i[1] ? operand_a_i : '1) : ovf ? (op_i[1] ? '0 : operand_a_i) : mul_res;
    // acc_q holds {product hi, multiplier} when multiplying, {remainder, dividend/quotient} when dividing
    sum      = {1'b0, acc_q[2*XLEN_P-1:XLEN_P]} + {1'b0, b_q};
    acc_mul  = acc_q[0] ? {sum, acc_q[XLEN_P-1:1]} : {1'b0, acc_q[2*XLEN_P-1:1]};
    sh       = {acc_q[2*XLEN_P-1:XLEN_P], acc_q[XLEN_P-1]};
    diff     = sh - {1'b0, b_q};
    acc_div  = {diff[XLEN_P] ? sh[XLEN_P-1:0] : diff[XLEN_P-1:0], acc_q[XLEN_P-2:0], ~diff[XLEN_P]};
    acc_nxt  = op_q[2] ? acc_div : acc_mul;
    prod     = neg_q ? -acc_nxt : acc_nxt;
    quo      = neg_q ? -acc_nxt[XLEN_P-1:0] : acc_nxt[XLEN_P-1:0];
    rem      = rneg_q ? -acc_nxt[2*XLEN_P-1:XLEN_P] : acc_nxt[2*XLEN_P-1:XLEN_P];
    fin      = op_q == 3'd0 ? prod[XLEN_P-1:0] : !op_q[2] ? prod[2*XLEN_P-1:XLEN_P] : op_q[1] ? rem : quo;
  end
  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;
  always_comb begin
    state_d = flush_i ? IDLE
            : accept ? (special ? DONE : BUSY)
            : (state_q == BUSY && last) ? DONE
            : (state_q == DONE && ready_i) ? IDLE
            : state_q;
  end
  always_comb begin
    ready_o  = state_q == IDLE;
    busy_o   = state_q != IDLE;
    valid_o  = state_q == DONE;
    result_o = state_q == DONE ? res_q : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q   <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      op_q   <= op_i;
      cnt_q  <= '0;
      acc_q  <= {{XLEN_P{1'b0}}, a_mag};
      b_q    <= b_mag;
      res_q  <= special ? sp_res : '0;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
    end else if (state_q == BUSY && !flush_i) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_nxt;
      if (last) res_q <= fin;
    end
  end
endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// tb_rv32_muldiv_unit: directed vectors for rv32_muldiv_unit; covers both builds of RV32_MULDIV_SINGLE_CYCLE_MUL_EN
module tb_rv32_muldiv_unit;
`ifdef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  logic clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1;
  logic ready_o, valid_o, busy_o;
  logic [2:0] op_i = '0;
  logic [31:0] operand_a_i = '0, operand_b_i = '0, result_o;
  int checks = 0, errors = 0;
  rv32_muldiv_unit #(.XLEN_P(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_i = op; operand_a_i = a; operand_b_i = b; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0; op_i = 3'd5; operand_a_i = '1; operand_b_i = '1;
  endtask
  task automatic wait_valid(output int n);
    @(negedge clk);
    n = 1;
    while (!valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    int n;
    start(op, a, b);
    wait_valid(n);
    check({tag, " result"}, result_o, exp);
    check({tag, " latency"}, n, lat);
    @(posedge clk);
    #1 check({tag, " ready after hand-off"}, {ready_o, valid_o, result_o}, {2'b10, 32'h0});
  endtask
  task automatic abort(input string tag, input bit use_rst);
    bit seen;
    start(3'd4, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0; flush_i = 1'b0;
    check({tag, " idle next cycle"}, {ready_o, busy_o, valid_o}, 3'b100);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    check({tag, " no valid"}, seen, 1'b0);
    run({tag, " DIV 9/3"}, 3'd4, 32'd9, 32'd3, 32'd3, 33);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    check("reset", {ready_o, busy_o, valid_o, result_o}, {3'b100, 32'h0});
    run("MUL", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, ML);
    run("MULH", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, ML);
    run("MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML);
    run("MULHSU", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, ML);
    run("DIV", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("REM", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run("DIVU by 0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("REM by 0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run("REM ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    run("DIV ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    ready_i = 1'b0;
    start(3'd5, 32'd100, 32'd7);
    wait_valid(n);
    check("hold latency", n, 33);
    repeat (5) begin
      check("hold stable", {valid_o, ready_o, result_o}, {2'b10, 32'd14});
      @(negedge clk);
    end
    ready_i = 1'b1;
    check("hold last", {valid_o, ready_o, result_o}, {2'b10, 32'd14});
    @(negedge clk);
    check("hold released", {valid_o, ready_o, result_o}, {2'b01, 32'd0});
    abort("flush", 1'b0);
    abort("reset", 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
